// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the frequency-meter measurement front end.
// Latency: n/a (types only).
// Backpressure: n/a.
package freq_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    MEAS  = 2'd2,
    LATCH = 2'd3
  } fsm_state_t;

  typedef logic [3:0] bcd_t;

  localparam logic        MODE_FREQ   = 1'b0;
  localparam logic        MODE_PERIOD = 1'b1;
  localparam logic [15:0] N_MAX       = 16'hFFFF;

  // True when a decade is about to roll over on its next increment.
  function automatic logic bcd_is_max(input bcd_t d);
    return d == 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD decade: counts 0..9 on inc, carry_out is combinational for same-cycle ripple.
// Latency: digit updates on the clock edge after inc; carry_out is immediate.
// Backpressure: none; every inc is counted.
module bcd_digit_counter
  import freq_meas_pkg::*;
(
  input  logic CLK_50,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output bcd_t digit,
  output logic carry_out
);

  assign carry_out = inc & bcd_is_max(digit);

  // Decade register: clear wins over increment, 9 wraps to 0.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= carry_out ? bcd_t'(0) : digit + 4'd1;
    end
  end

endmodule

// File: rtl/freq_gate_counter.sv
// Frequency (BCD gate count) / period (ref ticks) measurement; SIG_DEGLITCH_EN adds a 2-cycle glitch filter.
// Latency: pin to edge 3 cycles (4 with SIG_DEGLITCH_EN); results and Store appear 1 cycle after LATCH.
// Backpressure: none; Store is a one-cycle pulse and outputs hold until the next one.
module freq_gate_counter
  import freq_meas_pkg::*;
#(
  parameter int unsigned GATE_TICKS = 50_000_000,
  parameter int unsigned REF_DIV    = 5,
  parameter int unsigned TIMEOUT    = 100_000_000
) (
  input  logic        CLK_50,
  input  logic        RST,
  input  logic        Sig_in,
  input  logic        measure_mode,
  output bcd_t        LatchBCD0,
  output bcd_t        LatchBCD1,
  output bcd_t        LatchBCD2,
  output bcd_t        LatchBCD3,
  output logic [15:0] N,
  output logic        OF,
  output logic        Store
);

  localparam int GW = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
  localparam int DW = (REF_DIV > 1)    ? $clog2(REF_DIV)    : 1;
  localparam int TW = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;

  fsm_state_t    state, state_nxt;
  logic          mode_q;
  logic [GW-1:0] gate_cnt;
  logic [DW-1:0] div_cnt;
  logic [15:0]   ref_cnt;
  logic [TW-1:0] to_cnt;
  logic          ovf, timed_out, go_timeout;
  logic          s1, s2, s3, rise;
  bcd_t          dig0, dig1, dig2, dig3;
  logic          cy0, cy1, cy2, cy3;
  logic          cnt_en, dig_clr;

  wire mode_chg  = (measure_mode != mode_q);
  wire gate_last = (gate_cnt == GW'(GATE_TICKS - 1));
  wire to_last   = (to_cnt == TW'(TIMEOUT - 1));
  wire ref_tick  = (div_cnt == DW'(REF_DIV - 1));
  wire in_flight = (state == ARM) || (state == MEAS);

`ifdef SIG_DEGLITCH_EN
  logic s4, s5;

  // Input synchronizer plus two history flops for the glitch filter.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      {s1, s2, s3, s4, s5} <= '0;
    end else begin
      {s1, s2, s3, s4, s5} <= {Sig_in, s1, s2, s3, s4};
    end
  end

  // Accept an edge only after two low samples followed by two high samples.
  assign rise = s2 & s3 & ~s4 & ~s5;
`else
  // Input synchronizer plus one delay flop for edge detection.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      {s1, s2, s3} <= '0;
    end else begin
      {s1, s2, s3} <= {Sig_in, s1, s2};
    end
  end

  assign rise = s2 & ~s3;
`endif

  // FSM state register.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: mode change aborts in ARM/MEAS; in ARM a timeout beats a late rise, in MEAS the rise wins.
  always_comb begin
    state_nxt  = state;
    go_timeout = 1'b0;
    case (state)
      IDLE: state_nxt = ARM;
      ARM: begin
        if (mode_chg)                state_nxt = IDLE;
        else if (mode_q == MODE_FREQ) state_nxt = MEAS;
        else if (to_last) begin
          state_nxt  = LATCH;
          go_timeout = 1'b1;
        end
        else if (rise)               state_nxt = MEAS;
      end
      MEAS: begin
        if (mode_chg) state_nxt = IDLE;
        else if (mode_q == MODE_FREQ) begin
          if (gate_last) state_nxt = LATCH;
        end else if (rise) begin
          state_nxt = LATCH;
        end else if (to_last) begin
          state_nxt  = LATCH;
          go_timeout = 1'b1;
        end
      end
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working counters: cleared in IDLE, advanced while a measurement is in flight.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      mode_q    <= MODE_FREQ;
      gate_cnt  <= '0;
      div_cnt   <= '0;
      ref_cnt   <= '0;
      to_cnt    <= '0;
      ovf       <= 1'b0;
      timed_out <= 1'b0;
    end else if (state == IDLE) begin
      mode_q    <= measure_mode;
      gate_cnt  <= '0;
      div_cnt   <= '0;
      ref_cnt   <= '0;
      to_cnt    <= '0;
      ovf       <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      if (go_timeout) timed_out <= 1'b1;
      if (mode_q == MODE_FREQ) begin
        if (state == MEAS) gate_cnt <= gate_cnt + 1'b1;
        if (cy3) ovf <= 1'b1;
      end else begin
        if (in_flight) to_cnt <= to_cnt + 1'b1;
        if (state == ARM && rise) begin
          div_cnt <= '0;
          ref_cnt <= '0;
        end else if (state == MEAS) begin
          div_cnt <= ref_tick ? '0 : div_cnt + 1'b1;
          if (ref_tick) begin
            if (ref_cnt == N_MAX) ovf <= 1'b1;
            else                  ref_cnt <= ref_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign cnt_en  = (state == MEAS) && (mode_q == MODE_FREQ) && rise;
  assign dig_clr = (state == IDLE);

  bcd_digit_counter u_dig0 (.CLK_50(CLK_50), .RST(RST), .clr(dig_clr), .inc(cnt_en), .digit(dig0), .carry_out(cy0));
  bcd_digit_counter u_dig1 (.CLK_50(CLK_50), .RST(RST), .clr(dig_clr), .inc(cy0),    .digit(dig1), .carry_out(cy1));
  bcd_digit_counter u_dig2 (.CLK_50(CLK_50), .RST(RST), .clr(dig_clr), .inc(cy1),    .digit(dig2), .carry_out(cy2));
  bcd_digit_counter u_dig3 (.CLK_50(CLK_50), .RST(RST), .clr(dig_clr), .inc(cy2),    .digit(dig3), .carry_out(cy3));

  // Result latch: LATCH commits the active mode's result; Store marks the first cycle it is visible.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      LatchBCD0 <= '0;
      LatchBCD1 <= '0;
      LatchBCD2 <= '0;
      LatchBCD3 <= '0;
      N         <= '0;
      OF        <= 1'b0;
      Store     <= 1'b0;
    end else begin
      Store <= (state == LATCH);
      if (state == LATCH) begin
        OF <= ovf & ~timed_out;
        if (mode_q == MODE_FREQ) begin
          LatchBCD0 <= dig0;
          LatchBCD1 <= dig1;
          LatchBCD2 <= dig2;
          LatchBCD3 <= dig3;
        end else begin
          N <= timed_out ? 16'd0 : ref_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter (small gate/timeout parameters).
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_freq_gate_counter;
  import freq_meas_pkg::*;

  logic        CLK_50 = 1'b0;
  logic        RST = 1'b1;
  logic        Sig_in = 1'b0;
  logic        measure_mode = 1'b0;
  bcd_t        LatchBCD0, LatchBCD1, LatchBCD2, LatchBCD3;
  logic [15:0] N;
  logic        OF, Store;

  logic        RST2 = 1'b1;
  logic        Sig_in2 = 1'b0;
  logic        mode2 = 1'b0;
  bcd_t        d2_0, d2_1, d2_2, d2_3;
  logic [15:0] N2;
  logic        OF2, Store2;

  int tests = 0;
  int fails = 0;

  // Signal generator controls: 0 low, 1 high, 2 periodic.
  int sig_kind  = 0;
  int sig_per   = 8;
  bit glitch_en = 1'b0;
  bit sig2_en   = 1'b0;

  always #10 CLK_50 = ~CLK_50;

  freq_gate_counter #(.GATE_TICKS(1000), .REF_DIV(5), .TIMEOUT(4000)) u_dut (
    .CLK_50(CLK_50), .RST(RST), .Sig_in(Sig_in), .measure_mode(measure_mode),
    .LatchBCD0(LatchBCD0), .LatchBCD1(LatchBCD1), .LatchBCD2(LatchBCD2), .LatchBCD3(LatchBCD3),
    .N(N), .OF(OF), .Store(Store)
  );

  freq_gate_counter #(.GATE_TICKS(30000), .REF_DIV(5), .TIMEOUT(4000)) u_dut_wrap (
    .CLK_50(CLK_50), .RST(RST2), .Sig_in(Sig_in2), .measure_mode(mode2),
    .LatchBCD0(d2_0), .LatchBCD1(d2_1), .LatchBCD2(d2_2), .LatchBCD3(d2_3),
    .N(N2), .OF(OF2), .Store(Store2)
  );

  // Drives Sig_in (and Sig_in2) just after each rising clock edge.
  initial begin : sig_gen
    int ph;
    ph = 0;
    forever begin
      @(posedge CLK_50);
      #2;
      if (sig2_en) Sig_in2 = ~Sig_in2;
      case (sig_kind)
        0: begin Sig_in = 1'b0; ph = 0; end
        1: begin Sig_in = 1'b1; ph = 0; end
        default: begin
          if (ph >= sig_per) ph = 0;
          Sig_in = (ph < sig_per / 2);
          if (glitch_en && ph == sig_per / 4)       Sig_in = 1'b0;
          if (glitch_en && ph == (3 * sig_per) / 4) Sig_in = 1'b1;
          ph++;
        end
      endcase
    end
  end

  task automatic wait_store(input int budget, output bit got, output int waited);
    got = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge CLK_50);
      waited++;
      if (Store === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK_50);
    tests++;
    if ({LatchBCD3, LatchBCD2, LatchBCD1, LatchBCD0, N, OF, Store} !== 34'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", {LatchBCD3, LatchBCD2, LatchBCD1, LatchBCD0, N, OF, Store});
    end
    RST = 1'b0;
    @(negedge CLK_50);
    tests++;
    if (Store !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_store: got %b want 0", Store);
    end
  endtask

  task automatic test_freq_gate();
    bit got;
    int w;
    measure_mode = 1'b0;
    sig_per = 8;
    sig_kind = 2;
    wait_store(2100, got, w);
    wait_store(1100, got, w);
    tests++;
    if (!got || w != 1003) begin
      fails++;
      $display("FAIL freq_gate_period: got store=%0b after %0d cycles want 1003", got, w);
    end
    tests++;
    if ({LatchBCD3, LatchBCD2, LatchBCD1, LatchBCD0} !== 16'h0125 || OF !== 1'b0) begin
      fails++;
      $display("FAIL freq_gate_bcd: got %h OF=%b want 0125 OF=0", {LatchBCD3, LatchBCD2, LatchBCD1, LatchBCD0}, OF);
    end
    @(negedge CLK_50);
    tests++;
    if (Store !== 1'b0) begin
      fails++;
      $display("FAIL freq_store_width: got %b want 0", Store);
    end
  endtask

  task automatic test_freq_wrap();
    bit got;
    logic [15:0] exp_bcd;
    logic exp_of;
`ifdef SIG_DEGLITCH_EN
    exp_bcd = 16'h0000;
    exp_of = 1'b0;
`else
    exp_bcd = 16'h5000;
    exp_of = 1'b1;
`endif
    sig2_en = 1'b1;
    @(negedge CLK_50);
    RST2 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 31000 && !got; i++) begin
      @(negedge CLK_50);
      if (Store2 === 1'b1) got = 1'b1;
    end
    tests++;
    if (!got || {d2_3, d2_2, d2_1, d2_0} !== exp_bcd || OF2 !== exp_of) begin
      fails++;
      $display("FAIL freq_wrap: got store=%0b bcd=%h OF=%b want bcd=%h OF=%b",
               got, {d2_3, d2_2, d2_1, d2_0}, OF2, exp_bcd, exp_of);
    end
    RST2 = 1'b1;
    sig2_en = 1'b0;
  endtask

  task automatic test_period();
    bit got;
    int w;
    measure_mode = 1'b1;
    sig_per = 500;
    sig_kind = 2;
    wait_store(3000, got, w);
    for (int k = 0; k < 2; k++) begin
      wait_store(1500, got, w);
      tests++;
      if (!got || N !== 16'd100 || OF !== 1'b0) begin
        fails++;
        $display("FAIL period_n%0d: got store=%0b N=%0d OF=%b want N=100 OF=0", k, got, N, OF);
      end
      @(negedge CLK_50);
      tests++;
      if (Store !== 1'b0) begin
        fails++;
        $display("FAIL period_store_width%0d: got %b want 0", k, Store);
      end
    end
  endtask

  task automatic test_timeout();
    bit got;
    int w;
    sig_kind = 0;
    wait_store(6000, got, w);
    wait_store(4100, got, w);
    tests++;
    if (!got || w < 4000 || w > 4010 || N !== 16'd0 || OF !== 1'b0) begin
      fails++;
      $display("FAIL timeout_low: got store=%0b gap=%0d N=%0d OF=%b want gap 4000..4010 N=0 OF=0", got, w, N, OF);
    end
    sig_kind = 1;
    wait_store(6000, got, w);
    wait_store(4100, got, w);
    tests++;
    if (!got || N !== 16'd0 || OF !== 1'b0) begin
      fails++;
      $display("FAIL timeout_high: got store=%0b N=%0d OF=%b want N=0 OF=0", got, N, OF);
    end
  endtask

  task automatic test_mode_abort();
    bit got;
    int w;
    sig_per = 500;
    sig_kind = 2;
    repeat (10) @(negedge CLK_50);
    measure_mode = 1'b0;
    wait_store(1500, got, w);
    tests++;
    if (!got || {LatchBCD3, LatchBCD2, LatchBCD1, LatchBCD0} !== 16'h0002 || N !== 16'd0) begin
      fails++;
      $display("FAIL mode_switch_freq: got store=%0b bcd=%h N=%0d want bcd=0002 N=0",
               got, {LatchBCD3, LatchBCD2, LatchBCD1, LatchBCD0}, N);
    end
    repeat (500) @(negedge CLK_50);
    measure_mode = 1'b1;
    wait_store(2500, got, w);
    tests++;
    if (!got || N !== 16'd100 || {LatchBCD3, LatchBCD2, LatchBCD1, LatchBCD0} !== 16'h0002 || OF !== 1'b0) begin
      fails++;
      $display("FAIL mode_abort: got store=%0b N=%0d bcd=%h OF=%b want N=100 bcd=0002 OF=0",
               got, N, {LatchBCD3, LatchBCD2, LatchBCD1, LatchBCD0}, OF);
    end
  endtask

  task automatic test_reset_mid();
    int stores;
    measure_mode = 1'b0;
    repeat (300) @(negedge CLK_50);
    #3;
    RST = 1'b1;
    #1;
    tests++;
    if ({LatchBCD3, LatchBCD2, LatchBCD1, LatchBCD0, N, OF, Store} !== 34'd0) begin
      fails++;
      $display("FAIL reset_async: got %h want 0", {LatchBCD3, LatchBCD2, LatchBCD1, LatchBCD0, N, OF, Store});
    end
    @(negedge CLK_50);
    RST = 1'b0;
    stores = 0;
    repeat (900) begin
      @(negedge CLK_50);
      if (Store === 1'b1) stores++;
    end
    tests++;
    if (stores != 0) begin
      fails++;
      $display("FAIL reset_no_store: got %0d stores want 0", stores);
    end
  endtask

  task automatic test_deglitch();
    bit got;
    int w;
    measure_mode = 1'b1;
    sig_per = 500;
    glitch_en = 1'b1;
    sig_kind = 2;
    wait_store(3000, got, w);
    wait_store(1500, got, w);
    tests++;
`ifdef SIG_DEGLITCH_EN
    if (!got || N !== 16'd100) begin
      fails++;
      $display("FAIL deglitch_on: got store=%0b N=%0d want N=100", got, N);
    end
`else
    if (!got || N === 16'd100) begin
      fails++;
      $display("FAIL deglitch_off: got store=%0b N=%0d want N!=100", got, N);
    end
`endif
    glitch_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_freq_gate();
    test_freq_wrap();
    test_period();
    test_timeout();
    test_mode_abort();
    test_reset_mid();
    test_deglitch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
